// File: rtl/irrigation_valve_sequencer_if.sv
// Panel-side bundle for irrigation_valve_sequencer: permission, sensor and timebase in;
// valve drive and session status out.
interface irrigation_valve_sequencer_if #(
    parameter int unsigned CYC_W = 4
);
    logic             irrigation;
    logic             error;
    logic             mode;
    logic             tick;
    logic             dripper;
    logic             sprinkler;
    logic             busy;
    logic             done;
    logic             fault;
    logic             lockout;
    logic [CYC_W-1:0] cycles;

    modport master (
        output irrigation, error, mode, tick,
        input  dripper, sprinkler, busy, done, fault, lockout, cycles
    );

    modport slave (
        input  irrigation, error, mode, tick,
        output dripper, sprinkler, busy, done, fault, lockout, cycles
    );
endinterface

// File: rtl/irrigation_valve_sequencer.sv
// Timed water/soak valve sequencer with registered Moore outputs and a tick-strobe timebase.
// Optional per-session cycle limit enabled by defining IRRIGATION_CYCLE_LIMIT_EN.
module irrigation_valve_sequencer #(
    parameter int unsigned ON_TICKS   = 8,
    parameter int unsigned SOAK_TICKS = 4,
    parameter int unsigned MAX_CYCLES = 3,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned CYC_W      = 4
) (
    input logic                         clock,
    input logic                         reset,
    irrigation_valve_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWater,
        StSoak,
        StFault,
        StLockout
    } state_e;

    localparam logic [CNT_W-1:0] OnLast   = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] SoakLast = CNT_W'(SOAK_TICKS - 1);
    localparam logic [CYC_W-1:0] CycSat   = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic             mode_q, mode_d;
    logic             drip_q, drip_d;
    logic             spr_q, spr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic             lock_q, lock_d;
    logic             on_exp, soak_exp, at_limit;

    assign on_exp   = bus.tick && (tcnt_q == OnLast);
    assign soak_exp = bus.tick && (tcnt_q == SoakLast);

`ifdef IRRIGATION_CYCLE_LIMIT_EN
    assign at_limit = (cycles_q == CYC_W'(MAX_CYCLES));
`else
    logic unused_max_cycles;
    assign at_limit          = 1'b0;
    assign unused_max_cycles = ^MAX_CYCLES;
`endif

    always_comb begin
        state_d  = state_q;
        cycles_d = cycles_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.error) begin
                    state_d = StFault;
                end else if (bus.irrigation) begin
                    state_d  = StWater;
                    mode_d   = bus.mode;
                    cycles_d = '0;
                end
            end
            StWater: begin
                if (bus.error) begin
                    state_d = StFault;
                end else if (!bus.irrigation) begin
                    state_d = StIdle;
                end else if (on_exp) begin
                    state_d = StSoak;
                    if (cycles_q != CycSat) cycles_d = cycles_q + 1'b1;
                end
            end
            StSoak: begin
                // A dropped request only takes effect once the soak has run its full length.
                if (bus.error) begin
                    state_d = StFault;
                end else if (soak_exp) begin
                    if (!bus.irrigation) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (at_limit) begin
                        state_d = StLockout;
                    end else begin
                        state_d = StWater;
                    end
                end
            end
            StFault: begin
                if (!bus.error && !bus.irrigation) state_d = StIdle;
            end
            StLockout: begin
                if (bus.error) begin
                    state_d = StFault;
                end else if (!bus.irrigation) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counter restarts on every state change, so the entry-clock tick is never counted.
    always_comb begin
        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (bus.tick && (state_q == StWater || state_q == StSoak)) begin
            tcnt_d = tcnt_q + 1'b1;
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    always_comb begin
        drip_d  = (state_d == StWater) && !mode_d;
        spr_d   = (state_d == StWater) && mode_d;
        busy_d  = (state_d != StIdle);
        fault_d = (state_d == StFault);
`ifdef IRRIGATION_CYCLE_LIMIT_EN
        lock_d  = (state_d == StLockout);
`else
        lock_d  = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            tcnt_q   <= '0;
            cycles_q <= '0;
            mode_q   <= 1'b0;
            drip_q   <= 1'b0;
            spr_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            cycles_q <= cycles_d;
            mode_q   <= mode_d;
            drip_q   <= drip_d;
            spr_q    <= spr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            lock_q   <= lock_d;
        end
    end

    assign bus.dripper   = drip_q;
    assign bus.sprinkler = spr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;
    assign bus.lockout   = lock_q;
    assign bus.cycles    = cycles_q;

endmodule
